// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback result stage.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  // Architectural register 0 is hard-wired; writes to it are dropped.
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // One buffered writeback: destination register and result data.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam wb_entry_t ENTRY_ZERO = '{rd: 5'd0, data: 32'd0};

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry result buffer with 1-bit pointers and an explicit occupancy count.
// The count, not pointer equality, separates full from empty.
module wb_skid_fifo
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  wb_entry_t  push_entry,
  input  logic       pop,
  output logic [1:0] count,
  output wb_entry_t  head,
  output wb_entry_t  youngest
);

  wb_entry_t  mem_q [DEPTH];
  wb_entry_t  mem_d [DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  // Next-state for storage, pointers and count; clear restarts both pointers but leaves data.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; asynchronous reset empties the buffer and zeroes storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ENTRY_ZERO;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head (oldest) and youngest read-outs, masked to zero when empty.
  always_comb begin
    if (count_q != 2'd0) begin
      head     = mem_q[rd_ptr_q];
      youngest = mem_q[~wr_ptr_q];
    end else begin
      head     = ENTRY_ZERO;
      youngest = ENTRY_ZERO;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wb_result_stage.sv
// Writeback stage: buffers execute results and drains them into one
// register-file write port, with a forwarding tap on the youngest entry.
module wb_result_stage
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  input  logic              wb_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        count
);

  logic      push_s;
  logic      pop_s;
  logic      accept_s;
  wb_entry_t push_entry_s;
  wb_entry_t head_s;
  wb_entry_t youngest_s;
  logic [1:0] count_s;

  // Handshake and enqueue decision; non-writing beats and r0 writes complete but are dropped.
  always_comb begin
    in_ready          = (count_s != 2'd2);
    accept_s          = in_valid & in_ready & ~flush;
    push_s            = accept_s & in_we & (in_rd != REG_ZERO);
    push_entry_s.rd   = in_rd;
    push_entry_s.data = in_data;
  end

  // Register-file port and forwarding tap, all derived from buffered state.
  always_comb begin
    rf_we     = (count_s != 2'd0) & wb_ready & ~flush;
    pop_s     = rf_we;
    rf_waddr  = head_s.rd;
    rf_wdata  = head_s.data;
    fwd_valid = (count_s != 2'd0);
    fwd_rd    = youngest_s.rd;
    fwd_data  = youngest_s.data;
    count     = count_s;
  end

  wb_skid_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .count      (count_s),
    .head       (head_s),
    .youngest   (youngest_s)
  );

endmodule
